// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and constants for the UART transmit arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    WAIT_LOW  = 3'd2,
    WAIT_HIGH = 3'd3,
    GAP       = 3'd4
  } tx_arb_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_arbiter_rr.sv
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin arbiter; the requester after ptr
//               has highest priority, wrapping modulo N.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx,
  output logic                 any
);

  localparam int c_IW = $clog2(N);

  logic [2*N-1:0]  w_dbl;
  logic [2*N-1:0]  w_masked;
  logic [c_IW-1:0] w_idx;

  assign w_dbl = {req, req};

  // Clearing bits 0..ptr of the doubled vector leaves ptr+1.. and the wrapped
  // copy, so the lowest surviving bit is the next requester in rotation.
  always_comb begin
    w_masked = w_dbl;
    for (int j = 0; j < 2 * N; j++) begin
      if (j <= int'(ptr)) begin
        w_masked[j] = 1'b0;
      end
    end
  end

  always_comb begin
    w_idx = '0;
    for (int j = 2 * N - 1; j >= 0; j--) begin
      if (w_masked[j]) begin
        w_idx = (j >= N) ? c_IW'(j - N) : c_IW'(j);
      end
    end
  end

  always_comb begin
    gnt = '0;
    for (int i = 0; i < N; i++) begin
      gnt[i] = any && (w_idx == c_IW'(i));
    end
  end

  assign any     = |req;
  assign gnt_idx = w_idx;

endmodule

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Round-robin sharing of one UART transmitter between NUM_REQ
//               byte sources, with start handshake, timeout and frame gap.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int START_TIMEOUT = 16,
  parameter int GAP_CYCLES    = 0
) (
  input  logic                           clk_10ns,
  input  logic                           uart_reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [UART_DATA_W*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]             req_ack,
  input  logic                           uart_tx_ready,
  output logic                           uart_tx_start,
  output logic [UART_DATA_W-1:0]         uart_transmit_data,
  output logic                           busy,
  output logic [$clog2(NUM_REQ)-1:0]     grant_id,
  output logic                           timeout_err
);

  localparam int c_ID_W  = $clog2(NUM_REQ);
  localparam int c_TMR_W = $clog2(max_int(START_TIMEOUT, GAP_CYCLES) + 1);
  localparam logic [c_TMR_W-1:0] c_TO_LAST  = c_TMR_W'(START_TIMEOUT - 1);
  localparam logic [c_TMR_W-1:0] c_GAP_LAST = c_TMR_W'(max_int(GAP_CYCLES, 1) - 1);
  localparam logic [c_TMR_W-1:0] c_TMR_ONE  = c_TMR_W'(1);

  tx_arb_state_t          r_state;
  tx_arb_state_t          w_state_next;
  logic [c_TMR_W-1:0]     r_timer;
  logic [c_TMR_W-1:0]     w_timer_next;
  logic [c_ID_W-1:0]      r_rr_ptr;
  logic [c_ID_W-1:0]      r_grant_id;
  logic [UART_DATA_W-1:0] r_tx_data;
  logic                   r_timeout;
  logic [NUM_REQ-1:0]     w_gnt;
  logic [c_ID_W-1:0]      w_gnt_idx;
  logic                   w_any;
  logic                   w_grant;
  logic                   w_timeout;
  logic [UART_DATA_W-1:0] w_req_bytes [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign w_req_bytes[i] = req_data[i*UART_DATA_W +: UART_DATA_W];
  end

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_rr (
    .req     (req_valid),
    .ptr     (r_rr_ptr),
    .gnt     (w_gnt),
    .gnt_idx (w_gnt_idx),
    .any     (w_any)
  );

  always_ff @(posedge clk_10ns or posedge uart_reset) begin
    if (uart_reset) begin
      r_state <= IDLE;
      r_timer <= '0;
    end else begin
      r_state <= w_state_next;
      r_timer <= w_timer_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_timer_next = r_timer;
    w_grant      = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      IDLE: begin
        // Reset gating keeps the ack low while the block is held in reset.
        if (uart_tx_ready && w_any && !uart_reset) begin
          w_grant      = 1'b1;
          w_state_next = START;
        end
      end
      START: begin
        w_timer_next = '0;
        w_state_next = WAIT_LOW;
      end
      WAIT_LOW: begin
        if (!uart_tx_ready) begin
          w_state_next = WAIT_HIGH;
        end else if (r_timer == c_TO_LAST) begin
          w_timeout    = 1'b1;
          w_state_next = IDLE;
        end else begin
          w_timer_next = r_timer + c_TMR_ONE;
        end
      end
      WAIT_HIGH: begin
        if (uart_tx_ready) begin
          w_timer_next = '0;
          w_state_next = (GAP_CYCLES > 0) ? GAP : IDLE;
        end
      end
      GAP: begin
        if (r_timer == c_GAP_LAST) begin
          w_state_next = IDLE;
        end else begin
          w_timer_next = r_timer + c_TMR_ONE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_10ns or posedge uart_reset) begin
    if (uart_reset) begin
      r_rr_ptr   <= c_ID_W'(NUM_REQ - 1);
      r_grant_id <= '0;
      r_tx_data  <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_timeout <= w_timeout;
      if (w_grant) begin
        r_rr_ptr   <= w_gnt_idx;
        r_grant_id <= w_gnt_idx;
        r_tx_data  <= w_req_bytes[w_gnt_idx];
      end
    end
  end

  assign req_ack            = w_grant ? w_gnt : '0;
  assign uart_tx_start      = (r_state == START);
  assign busy               = (r_state != IDLE);
  assign grant_id           = r_grant_id;
  assign uart_transmit_data = r_tx_data;
  assign timeout_err        = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// ============================================================================
// Module      : tb_uart_tx_arbiter
// Description : Self-checking bench for uart_tx_arbiter with a cycle-stamped
//               reference model, directed scenarios and random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_arbiter;

  localparam int N   = 4;
  localparam int ST  = 16;
  localparam int GAP = 0;
  localparam int INF = 1 << 30;

  logic           clk_10ns = 1'b0;
  logic           uart_reset = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   req_ack;
  logic           uart_tx_ready;
  logic           uart_tx_start;
  logic [7:0]     uart_transmit_data;
  logic           busy;
  logic [1:0]     grant_id;
  logic           timeout_err;

  logic [N-1:0]   g5_valid = 4'b0001;
  logic [8*N-1:0] g5_data = 32'h0000_005A;
  logic [N-1:0]   g5_ack;
  logic           g5_ready;
  logic           g5_start;
  logic [7:0]     g5_tx_data;
  logic           g5_busy;
  logic [1:0]     g5_gid;
  logic           g5_to;

  int n_tests = 0;
  int n_fail  = 0;

  bit rsp_drop = 1'b1;
  int rsp_d    = 2;
  int rsp_len  = 20;
  bit idle_low = 1'b0;

  logic [N-1:0] ack_q = '0;
  int obs_gnt[$];
  int obs_start[$];
  int obs_to[$];
  int g5_starts[$];

  // Reference model state, all expressed as cycle stamps.
  int         cyc       = 0;
  int         idle_from = 0;
  int         t_grant   = -100;
  int         t_fall    = -1;
  int         to_cycle  = -1;
  int         m_ptr     = N - 1;
  int         m_gid     = 0;
  logic [7:0] m_data    = '0;

  always #5 clk_10ns = ~clk_10ns;

  uart_tx_arbiter #(.NUM_REQ(N), .START_TIMEOUT(ST), .GAP_CYCLES(GAP)) dut (
    .clk_10ns           (clk_10ns),
    .uart_reset         (uart_reset),
    .req_valid          (req_valid),
    .req_data           (req_data),
    .req_ack            (req_ack),
    .uart_tx_ready      (uart_tx_ready),
    .uart_tx_start      (uart_tx_start),
    .uart_transmit_data (uart_transmit_data),
    .busy               (busy),
    .grant_id           (grant_id),
    .timeout_err        (timeout_err)
  );

  uart_tx_arbiter #(.NUM_REQ(N), .START_TIMEOUT(ST), .GAP_CYCLES(5)) dut_g5 (
    .clk_10ns           (clk_10ns),
    .uart_reset         (uart_reset),
    .req_valid          (g5_valid),
    .req_data           (g5_data),
    .req_ack            (g5_ack),
    .uart_tx_ready      (g5_ready),
    .uart_tx_start      (g5_start),
    .uart_transmit_data (g5_tx_data),
    .busy               (g5_busy),
    .grant_id           (g5_gid),
    .timeout_err        (g5_to)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic int q_at(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  // UART model: after a start, ready falls rsp_d cycles later for rsp_len cycles.
  initial begin
    uart_tx_ready = 1'b1;
    forever begin
      @(negedge clk_10ns);
      if (uart_tx_start && rsp_drop) begin
        repeat (rsp_d) @(posedge clk_10ns);
        #1 uart_tx_ready = 1'b0;
        repeat (rsp_len) @(posedge clk_10ns);
        #1 uart_tx_ready = 1'b1;
      end else begin
        @(posedge clk_10ns);
        #1 uart_tx_ready = !idle_low;
      end
    end
  end

  initial begin
    g5_ready = 1'b1;
    forever begin
      @(negedge clk_10ns);
      if (g5_start) begin
        repeat (2) @(posedge clk_10ns);
        #1 g5_ready = 1'b0;
        repeat (20) @(posedge clk_10ns);
        #1 g5_ready = 1'b1;
      end
    end
  end

  // Compare process: model predicts this cycle's outputs, then advances.
  always @(negedge clk_10ns) begin
    logic [N-1:0] e_ack;
    bit e_start, e_busy, e_to, g;
    int w;
    cyc++;
    ack_q = req_ack;
    for (int i = 0; i < N; i++) if (req_ack[i]) obs_gnt.push_back(i);
    if (uart_tx_start) obs_start.push_back(cyc);
    if (timeout_err) obs_to.push_back(cyc);
    if (g5_start) g5_starts.push_back(cyc);
    e_ack = '0; e_start = 1'b0; e_busy = 1'b0; e_to = 1'b0; g = 1'b0; w = 0;
    if (uart_reset) begin
      m_ptr = N - 1; m_gid = 0; m_data = '0;
      idle_from = cyc; t_grant = -100; t_fall = -1; to_cycle = -1;
    end else begin
      e_to   = (cyc == to_cycle);
      e_busy = (cyc < idle_from);
      if (!e_busy) begin
        if (uart_tx_ready && (req_valid != '0)) begin
          for (int k = 1; k <= N; k++) begin
            if (!g && req_valid[(m_ptr + k) % N]) begin
              g = 1'b1;
              w = (m_ptr + k) % N;
            end
          end
          e_ack[w] = 1'b1;
          t_grant = cyc; t_fall = -1; idle_from = INF;
        end
      end else begin
        e_start = (cyc == t_grant + 1);
        if (cyc >= t_grant + 2) begin
          if (t_fall < 0) begin
            if (!uart_tx_ready) t_fall = cyc;
            else if (cyc - (t_grant + 2) == ST - 1) begin
              to_cycle  = cyc + 1;
              idle_from = cyc + 1;
            end
          end else if (uart_tx_ready) begin
            idle_from = cyc + 1 + GAP;
          end
        end
      end
    end
    check("req_ack", 32'(req_ack), 32'(e_ack));
    check("tx_start", 32'(uart_tx_start), 32'(e_start));
    check("busy", 32'(busy), 32'(e_busy));
    check("timeout_err", 32'(timeout_err), 32'(e_to));
    check("tx_data", 32'(uart_transmit_data), 32'(m_data));
    check("grant_id", 32'(grant_id), 32'(m_gid));
    if (g) begin
      m_ptr = w; m_gid = w; m_data = req_data[8*w +: 8];
    end
  end

  task automatic run_cycles(input int n, input bit keep);
    for (int k = 0; k < n; k++) begin
      @(posedge clk_10ns); #1;
      if (!keep) req_valid = req_valid & ~ack_q;
    end
  endtask

  task automatic run_until_gnts(input int cnt, input int budget, input bit keep);
    int k;
    k = 0;
    while (obs_gnt.size() < cnt && k < budget) begin
      @(posedge clk_10ns); #1;
      if (!keep) req_valid = req_valid & ~ack_q;
      k++;
    end
    check("grant_wait", 32'(obs_gnt.size()), 32'(cnt));
  endtask

  task automatic clear_logs();
    obs_gnt.delete(); obs_start.delete(); obs_to.delete();
  endtask

  task automatic pulse_reset();
    @(posedge clk_10ns); #1 uart_reset = 1'b1;
    @(posedge clk_10ns); #1 uart_reset = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Reset values, with requests present to show acks stay low.
    req_valid = 4'b1111;
    repeat (3) @(posedge clk_10ns); #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_start", 32'(uart_tx_start), 32'd0);
    check("rst_ack", 32'(req_ack), 32'd0);
    check("rst_data", 32'(uart_transmit_data), 32'd0);
    req_valid = '0;
    uart_reset = 1'b0;

    // Single requester 0, byte A5.
    clear_logs();
    req_data = 32'h0000_00A5; req_valid = 4'b0001;
    run_cycles(60, 1'b0);
    check("single_gnt_cnt", 32'(obs_gnt.size()), 32'd1);
    check("single_gnt_id", 32'(q_at(obs_gnt, 0)), 32'd0);
    check("single_start_cnt", 32'(obs_start.size()), 32'd1);
    check("single_data", 32'(uart_transmit_data), 32'hA5);
    check("single_idle", 32'(busy), 32'd0);

    // Back-to-back from one requester: start spacing without gap.
    clear_logs();
    req_valid = 4'b0001;
    run_cycles(60, 1'b1);
    check("b2b_spacing", 32'(q_at(obs_start, 1) - q_at(obs_start, 0)), 32'd24);
    req_valid = '0;
    run_cycles(30, 1'b0);

    // All four requesting continuously after reset: 0,1,2,3,0.
    pulse_reset();
    clear_logs();
    rsp_d = 1; rsp_len = 3;
    req_data = 32'h1312_1110; req_valid = 4'b1111;
    run_until_gnts(5, 200, 1'b1);
    req_valid = '0;
    for (int i = 0; i < 5; i++) check("rr_order", 32'(q_at(obs_gnt, i)), 32'(i % 4));
    run_cycles(20, 1'b0);

    // Contention with rotation: grant 2, then 1 and 3 pending -> 3 then 1.
    clear_logs();
    req_data = 32'hD3C2_B1A0; req_valid = 4'b0100;
    run_until_gnts(1, 50, 1'b0);
    req_valid = 4'b1010;
    run_until_gnts(3, 100, 1'b0);
    check("contend_first", 32'(q_at(obs_gnt, 1)), 32'd3);
    check("contend_second", 32'(q_at(obs_gnt, 2)), 32'd1);
    run_cycles(20, 1'b0);

    // Timeout: UART never drops ready.
    clear_logs();
    rsp_drop = 1'b0;
    req_valid = 4'b0001;
    run_cycles(40, 1'b0);
    check("to_count", 32'(obs_to.size()), 32'd1);
    check("to_delay", 32'(q_at(obs_to, 0) - q_at(obs_start, 0)), 32'(ST + 1));
    rsp_drop = 1'b1;
    req_valid = 4'b0010;
    run_cycles(40, 1'b0);
    check("after_to_gnt", 32'(q_at(obs_gnt, 1)), 32'd1);

    // Ready low in IDLE blocks grants.
    idle_low = 1'b1;
    run_cycles(3, 1'b0);
    clear_logs();
    req_valid = 4'b0100;
    run_cycles(8, 1'b1);
    check("ready_low_nogrant", 32'(obs_gnt.size()), 32'd0);
    idle_low = 1'b0;
    run_cycles(40, 1'b0);
    check("ready_back_grant", 32'(obs_gnt.size()), 32'd1);

    // Reset in WAIT_HIGH, then 0 and 2 pending: 0 must win.
    rsp_d = 2; rsp_len = 30;
    clear_logs();
    req_valid = 4'b0001;
    run_cycles(8, 1'b0);
    check("mid_frame_busy", 32'(busy), 32'd1);
    #2 uart_reset = 1'b1;
    #1;
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_start", 32'(uart_tx_start), 32'd0);
    check("rst_mid_data", 32'(uart_transmit_data), 32'd0);
    check("rst_mid_gid", 32'(grant_id), 32'd0);
    clear_logs();
    req_valid = 4'b0101;
    @(posedge clk_10ns); #1 uart_reset = 1'b0;
    run_until_gnts(2, 150, 1'b0);
    check("rst_first", 32'(q_at(obs_gnt, 0)), 32'd0);
    check("rst_second", 32'(q_at(obs_gnt, 1)), 32'd2);
    run_cycles(20, 1'b0);

    // Random traffic against the model.
    for (int c = 0; c < 2500; c++) begin
      @(posedge clk_10ns); #1;
      if ($urandom_range(0, 15) == 0) begin
        rsp_d    = $urandom_range(1, 3);
        rsp_len  = $urandom_range(1, 12);
        rsp_drop = ($urandom_range(0, 7) != 0);
      end
      idle_low = ($urandom_range(0, 15) == 0);
      for (int i = 0; i < N; i++) begin
        if (ack_q[i]) begin
          if ($urandom_range(0, 1) == 1) req_data[8*i +: 8] = 8'($urandom);
          else req_valid[i] = 1'b0;
        end else if (req_valid[i]) begin
          if ($urandom_range(0, 31) == 0) req_valid[i] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          req_valid[i] = 1'b1;
          req_data[8*i +: 8] = 8'($urandom);
        end
      end
    end
    req_valid = '0; rsp_drop = 1'b1; idle_low = 1'b0;
    run_cycles(60, 1'b0);

    check("gap5_spacing", 32'(q_at(g5_starts, 1) - q_at(g5_starts, 0)), 32'd29);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
